stream_mux_rr: RTL and testbench

Parametrised N-channel stream multiplexer. It generalises the basic 2:1 select into WIDTH-bit data, N inputs, valid/ready handshakes, arbitration and packet locking. Each cycle it picks one requesting input channel, using round-robin or fixed priority, and loads that beat into a registered output stage. Once a packet starts, the grant stays on that channel until the beat marked last is accepted. It sits between several producers and one shared downstream consumer.

---
 rtl/stream_mux_rr_pkg.sv | 17 +
 rtl/stream_mux_rr_if.sv | 30 +++
 rtl/stream_mux_rr_arbiter.sv | 50 +++++
 rtl/stream_mux_rr.sv | 128 ++++++++++++
 tb/tb_stream_mux_rr.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants, FSM encoding and sizing helper for the stream_mux_rr slice.
package stream_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Channel-index width, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// N-channel producer side plus single consumer side of the stream mux.
interface stream_mux_rr_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = stream_mux_pkg::sel_width(N)
);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;

    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    // slave is the mux; master is the producers and consumer around it
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr+1 or fixed lowest-index priority,
// overridden by a lock onto a single channel.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            mode_i,
    input  logic            lock_i,
    input  logic [SELW-1:0] lock_ch_i,
    output logic [SELW-1:0] grant_o,
    output logic            grant_valid_o
);

    always_comb begin
        logic [SELW-1:0] cand;
        int unsigned     idx;
        grant_o       = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        idx           = 0;
        if (lock_i) begin
            grant_o       = lock_ch_i;
            grant_valid_o = req_i[lock_ch_i];
        end else if (mode_i) begin
            // Scan downward so the lowest requesting index is written last.
            for (int unsigned i = N; i > 0; i--) begin
                cand = SELW'(i - 1);
                if (req_i[cand]) begin
                    grant_o       = cand;
                    grant_valid_o = 1'b1;
                end
            end
        end else begin
            // Offset 1 (ptr+1) has highest priority, so it is visited last.
            for (int unsigned off = N; off >= 1; off--) begin
                idx  = (32'(ptr_i) + off) % N;
                cand = SELW'(idx);
                if (req_i[cand]) begin
                    grant_o       = cand;
                    grant_valid_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with packet locking and a registered
// output stage; arbitration is round-robin or fixed priority.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_RR,
    parameter int SELW  = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);

    state_e            state_q, state_d;
    logic [SELW-1:0]   lock_ch_q, lock_ch_d;
    logic [SELW-1:0]   ptr_q, ptr_d;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [SELW-1:0]   out_sel_q, out_sel_d;

    logic [SELW-1:0]   grant;
    logic              grant_valid;
    logic              load_en;
    logic              xfer;
    logic [WIDTH-1:0]  grant_data;
    logic              grant_last;
    logic [WIDTH-1:0]  in_beats [N];

    for (genvar g = 0; g < N; g++) begin : g_split
        assign in_beats[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req_i         (bus.in_valid),
        .ptr_i         (ptr_q),
        .mode_i        (MODE == MODE_FIXED),
        .lock_i        (state_q == ST_LOCKED),
        .lock_ch_i     (lock_ch_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    assign load_en    = !out_valid_q || bus.out_ready;
    assign xfer       = load_en && grant_valid;
    assign grant_data = in_beats[grant];
    assign grant_last = bus.in_last[grant];

    assign bus.in_ready = xfer ? (N'(1) << grant) : '0;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer && !grant_last) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = grant;
                end
            end
            ST_LOCKED: begin
                if (xfer && grant_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (MODE == MODE_RR && xfer && grant_last) begin
            ptr_d = grant;
        end
    end

    // Payload holds its last value when the stage drains without a new beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = grant_data;
                out_last_d = grant_last;
                out_sel_d  = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            ptr_q       <= SELW'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.in_ready));

    a_hold_stalled: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid && !bus.out_ready |=>
            bus.out_valid && $stable(bus.out_data) && $stable(bus.out_sel) && $stable(bus.out_last));

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: round-robin and fixed-priority instances.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.N(N), .WIDTH(WIDTH)) bus_rr ();
    stream_mux_rr_if #(.N(N), .WIDTH(WIDTH)) bus_fx ();

    stream_mux_rr #(.N(N), .WIDTH(WIDTH), .MODE(MODE_RR)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    stream_mux_rr #(.N(N), .WIDTH(WIDTH), .MODE(MODE_FIXED)) dut_fx (
        .clk (clk),
        .rst (rst),
        .bus (bus_fx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i carries tag + 0x11*i, so every channel and cycle is distinguishable.
    task automatic apply(input bit fx, input logic [3:0] v, input logic [3:0] l,
                         input logic ordy, input logic [7:0] tag);
        logic [31:0] d;
        for (int i = 0; i < N; i++) d[i*8 +: 8] = tag + 8'(i * 17);
        if (fx) begin
            bus_fx.in_valid = v;  bus_fx.in_last = l;  bus_fx.in_data = d;  bus_fx.out_ready = ordy;
            bus_rr.in_valid = '0; bus_rr.in_last = '0; bus_rr.in_data = '0; bus_rr.out_ready = 1'b1;
        end else begin
            bus_rr.in_valid = v;  bus_rr.in_last = l;  bus_rr.in_data = d;  bus_rr.out_ready = ordy;
            bus_fx.in_valid = '0; bus_fx.in_last = '0; bus_fx.in_data = '0; bus_fx.out_ready = 1'b1;
        end
        #2;
    endtask

    task automatic push_exp(input logic [3:0] exp, input logic [3:0] l, input logic [7:0] tag);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (exp[i]) begin
                b.sel  = 2'(i);
                b.data = tag + 8'(i * 17);
                b.last = l[i];
                sb.push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(1'b0, 4'b0000, 4'b0000, 1'b1, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [3:0] tv [4];
        logic [3:0] te [4];
        beat_t      got;
        rst = 1'b1;
        apply(1'b0, 4'b0011, 4'b0011, 1'b1, 8'h00);
        tick();
        tick();
        vectors++;
        if ({bus_rr.out_valid, bus_rr.out_data, bus_rr.out_last, bus_rr.out_sel} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b data=%h last=%b sel=%0d want all 0",
                     bus_rr.out_valid, bus_rr.out_data, bus_rr.out_last, bus_rr.out_sel);
        end
        vectors++;
        if (bus_fx.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fx_valid: got %b want 0", bus_fx.out_valid);
        end
        rst = 1'b0;
        sb.delete();
        tv = '{4'b0011, 4'b0011, 4'b0000, 4'b0000};
        te = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, tv[c], 4'b1111, 1'b1, 8'(8'h01 + c));
            vectors++;
            if (bus_rr.in_ready !== te[c]) begin
                miscompares++;
                $display("FAIL reset_rdy cyc %0d: got %b want %b", c, bus_rr.in_ready, te[c]);
            end
            vectors++;
            if (sb.size() == 0) begin
                if (bus_rr.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_idle cyc %0d: out_valid got %b want 0", c, bus_rr.out_valid);
                end
            end else begin
                got = '{bus_rr.out_sel, bus_rr.out_data, bus_rr.out_last};
                if (bus_rr.out_valid !== 1'b1 || got !== sb[0]) begin
                    miscompares++;
                    $display("FAIL reset_beat cyc %0d: got v=%b sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                             c, bus_rr.out_valid, got.sel, got.data, got.last, sb[0].sel, sb[0].data, sb[0].last);
                end
                void'(sb.pop_front());
            end
            push_exp(te[c], 4'b1111, 8'(8'h01 + c));
            tick();
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        beat_t      got;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            exp = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            apply(1'b0, (c < 8) ? 4'b1111 : 4'b0000, 4'b1111, 1'b1, 8'(8'h20 + c));
            vectors++;
            if (bus_rr.in_ready !== exp) begin
                miscompares++;
                $display("FAIL rr_rdy cyc %0d: got %b want %b", c, bus_rr.in_ready, exp);
            end
            vectors++;
            if (sb.size() == 0) begin
                if (bus_rr.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rr_idle cyc %0d: out_valid got %b want 0", c, bus_rr.out_valid);
                end
            end else begin
                got = '{bus_rr.out_sel, bus_rr.out_data, bus_rr.out_last};
                if (bus_rr.out_valid !== 1'b1 || got !== sb[0]) begin
                    miscompares++;
                    $display("FAIL rr_beat cyc %0d: got v=%b sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                             c, bus_rr.out_valid, got.sel, got.data, got.last, sb[0].sel, sb[0].data, sb[0].last);
                end
                void'(sb.pop_front());
            end
            push_exp(exp, 4'b1111, 8'(8'h20 + c));
            tick();
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0] tv [9];
        logic [3:0] tl [9];
        logic [3:0] te [9];
        beat_t      got;
        do_reset();
        tv = '{4'b0100, 4'b0111, 4'b0111, 4'b1011, 4'b0011, 4'b0010, 4'b0011, 4'b0000, 4'b0000};
        tl = '{4'b0000, 4'b0000, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        te = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        for (int c = 0; c < 9; c++) begin
            apply(1'b0, tv[c], tl[c], 1'b1, 8'(8'h40 + c));
            vectors++;
            if (bus_rr.in_ready !== te[c]) begin
                miscompares++;
                $display("FAIL lock_rdy cyc %0d: got %b want %b", c, bus_rr.in_ready, te[c]);
            end
            vectors++;
            if (sb.size() == 0) begin
                if (bus_rr.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lock_idle cyc %0d: out_valid got %b want 0", c, bus_rr.out_valid);
                end
            end else begin
                got = '{bus_rr.out_sel, bus_rr.out_data, bus_rr.out_last};
                if (bus_rr.out_valid !== 1'b1 || got !== sb[0]) begin
                    miscompares++;
                    $display("FAIL lock_beat cyc %0d: got v=%b sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                             c, bus_rr.out_valid, got.sel, got.data, got.last, sb[0].sel, sb[0].data, sb[0].last);
                end
                void'(sb.pop_front());
            end
            push_exp(te[c], tl[c], 8'(8'h40 + c));
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] te [10];
        logic       tr [10];
        logic [7:0] tag;
        beat_t      got;
        do_reset();
        te = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        tr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 10; c++) begin
            tag = (c == 0) ? 8'hA5 : 8'(c * 16 + 3);
            apply(1'b0, (c == 0) ? 4'b0001 : ((c < 8) ? 4'b0011 : 4'b0000), 4'b1111, tr[c], tag);
            vectors++;
            if (bus_rr.in_ready !== te[c]) begin
                miscompares++;
                $display("FAIL bp_rdy cyc %0d: got %b want %b", c, bus_rr.in_ready, te[c]);
            end
            vectors++;
            if (sb.size() == 0) begin
                if (bus_rr.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_idle cyc %0d: out_valid got %b want 0", c, bus_rr.out_valid);
                end
            end else begin
                got = '{bus_rr.out_sel, bus_rr.out_data, bus_rr.out_last};
                if (bus_rr.out_valid !== 1'b1 || got !== sb[0]) begin
                    miscompares++;
                    $display("FAIL bp_beat cyc %0d: got v=%b sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                             c, bus_rr.out_valid, got.sel, got.data, got.last, sb[0].sel, sb[0].data, sb[0].last);
                end
                if (tr[c]) void'(sb.pop_front());
            end
            push_exp(te[c], 4'b1111, tag);
            tick();
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0] tv [8];
        logic [3:0] te [8];
        beat_t      got;
        do_reset();
        tv = '{4'b1000, 4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1000, 4'b0000, 4'b0000};
        te = '{4'b1000, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
        for (int c = 0; c < 8; c++) begin
            apply(1'b1, tv[c], 4'b1111, 1'b1, 8'(8'h60 + c));
            vectors++;
            if (bus_fx.in_ready !== te[c]) begin
                miscompares++;
                $display("FAIL fixed_rdy cyc %0d: got %b want %b", c, bus_fx.in_ready, te[c]);
            end
            vectors++;
            if (sb.size() == 0) begin
                if (bus_fx.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fixed_idle cyc %0d: out_valid got %b want 0", c, bus_fx.out_valid);
                end
            end else begin
                got = '{bus_fx.out_sel, bus_fx.out_data, bus_fx.out_last};
                if (bus_fx.out_valid !== 1'b1 || got !== sb[0]) begin
                    miscompares++;
                    $display("FAIL fixed_beat cyc %0d: got v=%b sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                             c, bus_fx.out_valid, got.sel, got.data, got.last, sb[0].sel, sb[0].data, sb[0].last);
                end
                void'(sb.pop_front());
            end
            push_exp(te[c], 4'b1111, 8'(8'h60 + c));
            tick();
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t got;
        beat_t exp;
        do_reset();
        apply(1'b0, 4'b0010, 4'b0000, 1'b1, 8'h40);
        vectors++;
        if (bus_rr.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_first_rdy: got %b want 0010", bus_rr.in_ready);
        end
        push_exp(4'b0010, 4'b0000, 8'h40);
        tick();
        got = '{bus_rr.out_sel, bus_rr.out_data, bus_rr.out_last};
        exp = sb.pop_front();
        vectors++;
        if (bus_rr.out_valid !== 1'b1 || got !== exp) begin
            miscompares++;
            $display("FAIL mid_first_beat: got v=%b sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                     bus_rr.out_valid, got.sel, got.data, got.last, exp.sel, exp.data, exp.last);
        end
        rst = 1'b1;
        apply(1'b0, 4'b0011, 4'b0000, 1'b1, 8'h50);
        tick();
        vectors++;
        if ({bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel} !== 11'h000) begin
            miscompares++;
            $display("FAIL mid_reset_out: got v=%b data=%h sel=%0d want all 0",
                     bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
        end
        rst = 1'b0;
        sb.delete();
        apply(1'b0, 4'b0011, 4'b0001, 1'b1, 8'h60);
        vectors++;
        if (bus_rr.in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_regrant_rdy: got %b want 0001", bus_rr.in_ready);
        end
        push_exp(4'b0001, 4'b0001, 8'h60);
        tick();
        apply(1'b0, 4'b0000, 4'b0000, 1'b1, 8'h70);
        got = '{bus_rr.out_sel, bus_rr.out_data, bus_rr.out_last};
        exp = sb.pop_front();
        vectors++;
        if (bus_rr.out_valid !== 1'b1 || got !== exp) begin
            miscompares++;
            $display("FAIL mid_regrant_beat: got v=%b sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                     bus_rr.out_valid, got.sel, got.data, got.last, exp.sel, exp.data, exp.last);
        end
        tick();
        vectors++;
        if (bus_rr.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_drain: out_valid got %b want 0", bus_rr.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_fixed_priority();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
